// File: rtl/c7bexu_rdpipe.sv
// c7bexu_rdpipe: destination-register tracking pipeline for the EXU.
// Carries rd / write-enable / load tags from decode through E, M and W,
// detects load-use hazards (one bubble), honours memory-stage holds and
// decode flushes, and counts load-use bubble cycles.
//
// Flow control: stall_d is the only back-pressure toward decode. When
// stall_d=1 the D instruction is not consumed and must be presented again
// next cycle. hold_m freezes E and M in the same cycle it is asserted.
// flush_d kills the D instruction without stalling.
module c7bexu_rdpipe #(
   parameter int AW    = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_d,
   input  logic [AW-1:0]    rd_d,
   input  logic             wen_d,
   input  logic             ld_d,
   input  logic [AW-1:0]    rs1_d,
   input  logic             rs1_use_d,
   input  logic [AW-1:0]    rs2_d,
   input  logic             rs2_use_d,
   input  logic             flush_d,
   input  logic             hold_m,
   output logic [AW-1:0]    rd_e,
   output logic             wen_e,
   output logic [AW-1:0]    rd_m,
   output logic             wen_m,
   output logic [AW-1:0]    rd_w,
   output logic             wen_w,
   output logic             stall_d,
   output logic [CNT_W-1:0] lduse_cnt
);

   // E stage
   logic             r_v_e;
   logic [AW-1:0]    r_rd_e;
   logic             r_w_e;
   logic             r_ld_e;
   // M stage
   logic             r_v_m;
   logic [AW-1:0]    r_rd_m;
   logic             r_w_m;
   // W stage
   logic             r_v_w;
   logic [AW-1:0]    r_rd_w;
   logic             r_w_w;
   // load-use bubble counter
   logic [CNT_W-1:0] r_cnt;

   logic             w_w_d;
   logic             w_rs1_hit;
   logic             w_rs2_hit;
   logic             w_lduse;
   logic             w_lduse_evt;
   logic             w_e_bubble;

   // Hazard detection and capture qualification for the D instruction.
   // x0 writes are dropped at capture so they never surface as an enable.
   always_comb begin
      w_w_d       = wen_d & (rd_d != '0);
      w_rs1_hit   = rs1_use_d & (rs1_d == r_rd_e);
      w_rs2_hit   = rs2_use_d & (rs2_d == r_rd_e);
      w_lduse     = valid_d & r_v_e & r_ld_e & r_w_e & (w_rs1_hit | w_rs2_hit);
      // A killed D instruction never stalls; hold dominates everything.
      w_lduse_evt = w_lduse & ~flush_d & ~hold_m;
      w_e_bubble  = ~valid_d | flush_d | w_lduse;
   end

   // Pipeline advance: hold freezes E/M and drains W; otherwise shift.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_v_e  <= 1'b0;
         r_rd_e <= '0;
         r_w_e  <= 1'b0;
         r_ld_e <= 1'b0;
         r_v_m  <= 1'b0;
         r_rd_m <= '0;
         r_w_m  <= 1'b0;
         r_v_w  <= 1'b0;
         r_rd_w <= '0;
         r_w_w  <= 1'b0;
      end else if (hold_m) begin
         r_v_w  <= 1'b0;
         r_rd_w <= '0;
         r_w_w  <= 1'b0;
      end else begin
         r_v_w  <= r_v_m;
         r_rd_w <= r_rd_m;
         r_w_w  <= r_w_m;
         r_v_m  <= r_v_e;
         r_rd_m <= r_rd_e;
         r_w_m  <= r_w_e;
         if (w_e_bubble) begin
            r_v_e  <= 1'b0;
            r_rd_e <= '0;
            r_w_e  <= 1'b0;
            r_ld_e <= 1'b0;
         end else begin
            r_v_e  <= 1'b1;
            r_rd_e <= rd_d;
            r_w_e  <= w_w_d;
            r_ld_e <= ld_d;
         end
      end
   end

   // Saturating count of load-use bubble cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_lduse_evt && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Output drive: qualified enables and same-cycle stall.
   always_comb begin
      rd_e      = r_rd_e;
      wen_e     = r_v_e & r_w_e;
      rd_m      = r_rd_m;
      wen_m     = r_v_m & r_w_m;
      rd_w      = r_rd_w;
      wen_w     = r_v_w & r_w_w;
      stall_d   = hold_m | (w_lduse & ~flush_d);
      lduse_cnt = r_cnt;
   end

endmodule

// File: tb/tb_c7bexu_rdpipe.sv
// Directed bench for c7bexu_rdpipe. The counter is built narrow so that
// saturation is reached in a few dozen cycles.
module tb_c7bexu_rdpipe;

  localparam int AW    = 5;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             valid_d;
  logic [AW-1:0]    rd_d;
  logic             wen_d;
  logic             ld_d;
  logic [AW-1:0]    rs1_d;
  logic             rs1_use_d;
  logic [AW-1:0]    rs2_d;
  logic             rs2_use_d;
  logic             flush_d;
  logic             hold_m;
  logic [AW-1:0]    rd_e;
  logic             wen_e;
  logic [AW-1:0]    rd_m;
  logic             wen_m;
  logic [AW-1:0]    rd_w;
  logic             wen_w;
  logic             stall_d;
  logic [CNT_W-1:0] lduse_cnt;

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];

  c7bexu_rdpipe #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .valid_d(valid_d), .rd_d(rd_d), .wen_d(wen_d), .ld_d(ld_d),
    .rs1_d(rs1_d), .rs1_use_d(rs1_use_d), .rs2_d(rs2_d), .rs2_use_d(rs2_use_d),
    .flush_d(flush_d), .hold_m(hold_m),
    .rd_e(rd_e), .wen_e(wen_e), .rd_m(rd_m), .wen_m(wen_m),
    .rd_w(rd_w), .wen_w(wen_w), .stall_d(stall_d), .lduse_cnt(lduse_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic v, input logic [AW-1:0] rd, input logic we, input logic ld,
                         input logic [AW-1:0] r1, input logic u1,
                         input logic [AW-1:0] r2, input logic u2);
    valid_d = v; rd_d = rd; wen_d = we; ld_d = ld;
    rs1_d = r1; rs1_use_d = u1; rs2_d = r2; rs2_use_d = u2;
  endtask

  task automatic idle_d();
    drive_d(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    idle_d();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; flush_d = 1'b0; hold_m = 1'b0;
    idle_d();
    repeat (2) tick();
    reset = 1'b0;

    // 1. reset with a full pipe
    for (int i = 1; i <= 3; i++) begin
      drive_d(1'b1, AW'(i), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      tick();
    end
    check("full_pipe_wen_w", {31'd0, wen_w}, 1);
    reset = 1'b1;
    tick();
    check("rst_wen_e", {31'd0, wen_e}, 0);
    check("rst_wen_m", {31'd0, wen_m}, 0);
    check("rst_wen_w", {31'd0, wen_w}, 0);
    check("rst_stall", {31'd0, stall_d}, 0);
    check("rst_cnt", 32'(lduse_cnt), 0);
    reset = 1'b0;
    idle_d();
    tick();
    check("post_rst_wen_w", {31'd0, wen_w}, 0);
    drain();

    // 2. back-to-back ALU
    drive_d(1'b1, 5'd5, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    #1 check("alu_stall", {31'd0, stall_d}, 0);
    tick();
    idle_d();
    check("alu_rd_e", 32'(rd_e), 5);
    tick();
    check("alu_rd_m", 32'(rd_m), 5);
    check("alu_wen_m", {31'd0, wen_m}, 1);
    tick();
    check("alu_rd_w", 32'(rd_w), 5);
    check("alu_wen_w", {31'd0, wen_w}, 1);
    tick();

    // 2b. stream of ALU writes (one to x0) observed at W through the queue
    drive_d(1'b1, 5'd6, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); exp_q.push_back(5'd6); tick();
    drive_d(1'b1, 5'd0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); tick();
    drive_d(1'b1, 5'd9, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); exp_q.push_back(5'd9); tick();
    idle_d();
    for (int c = 0; c < 6; c++) begin
      if (wen_w) begin
        if (exp_q.size() == 0) check("stream_extra_wen_w", 32'(rd_w), 32'hFFFF);
        else check("stream_rd_w", 32'(rd_w), 32'(exp_q.pop_front()));
      end
      tick();
    end
    check("stream_left", exp_q.size(), 0);

    // 3. load-use
    drive_d(1'b1, 5'd7, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
    tick();
    drive_d(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 1'b1, '0, 1'b0);
    #1 check("lu_stall", {31'd0, stall_d}, 1);
    tick();
    check("lu_bubble_wen_e", {31'd0, wen_e}, 0);
    check("lu_cnt", 32'(lduse_cnt), 1);
    check("lu_load_in_m", 32'(rd_m), 7);
    check("lu_stall_off", {31'd0, stall_d}, 0);
    tick();
    check("lu_consumer_rd_e", 32'(rd_e), 8);
    check("lu_consumer_wen_e", {31'd0, wen_e}, 1);
    drain();

    // 4a. load to x0 then use of x0
    drive_d(1'b1, 5'd0, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
    tick();
    check("x0_wen_e", {31'd0, wen_e}, 0);
    drive_d(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b1, '0, 1'b0);
    #1 check("x0_stall", {31'd0, stall_d}, 0);
    tick();
    check("x0_wen_m", {31'd0, wen_m}, 0);
    check("x0_consumer_wen_e", {31'd0, wen_e}, 1);
    check("x0_cnt", 32'(lduse_cnt), 1);
    drain();

    // 4b. load-use killed by flush
    drive_d(1'b1, 5'd7, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
    tick();
    drive_d(1'b1, 5'd8, 1'b1, 1'b0, '0, 1'b0, 5'd7, 1'b1);
    flush_d = 1'b1;
    #1 check("fl_stall", {31'd0, stall_d}, 0);
    tick();
    flush_d = 1'b0;
    check("fl_bubble_wen_e", {31'd0, wen_e}, 0);
    check("fl_cnt", 32'(lduse_cnt), 1);
    drain();

    // 5. hold_m for three cycles
    drive_d(1'b1, 5'd4, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    drive_d(1'b1, 5'd3, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    idle_d();
    hold_m = 1'b1;
    #1 check("hold_stall", {31'd0, stall_d}, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_rd_e", 32'(rd_e), 3);
      check("hold_rd_m", 32'(rd_m), 4);
      check("hold_wen_m", {31'd0, wen_m}, 1);
      check("hold_wen_w", {31'd0, wen_w}, 0);
    end
    hold_m = 1'b0;
    tick();
    check("rel_wen_w", {31'd0, wen_w}, 1);
    check("rel_rd_w", 32'(rd_w), 4);
    check("rel_rd_m", 32'(rd_m), 3);
    drain();

    // 5b. hold over a pending load-use
    drive_d(1'b1, 5'd7, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
    tick();
    drive_d(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 1'b1, '0, 1'b0);
    hold_m = 1'b1;
    tick();
    check("hlu_cnt_held", 32'(lduse_cnt), 1);
    check("hlu_rd_e", 32'(rd_e), 7);
    hold_m = 1'b0;
    #1 check("hlu_stall_after", {31'd0, stall_d}, 1);
    tick();
    check("hlu_cnt", 32'(lduse_cnt), 2);
    check("hlu_bubble_wen_e", {31'd0, wen_e}, 0);
    drain();

    // 6. counter saturation: a load reading its own rd every cycle gives one event per two cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_d(1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, '0, 1'b0);
    repeat (28) tick();
    check("sat_cnt_14", 32'(lduse_cnt), 14);
    repeat (12) tick();
    check("sat_cnt_max", 32'(lduse_cnt), 15);
    idle_d();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
